iob_eth_tx_gen: RTL and testbench



---
 rtl/iob_eth_tx_gen.sv | 172 +++++++++++++++++
 tb/tb_iob_eth_tx_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_eth_tx_gen.sv
// Ethernet TX framer: preamble/SFD, frame-buffer body, optional zero pad, CRC-32 FCS, IFG.
// Define ETH_TX_PAD_EN to pad short frames to a 60-byte body before the FCS.
module iob_eth_tx_gen #(
  parameter int DATA_W         = 4,
  parameter int ADDR_W         = 11,
  parameter int IFG_BYTES      = 12,
  parameter int PREAMBLE_BYTES = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              send,
  input  logic [ADDR_W-1:0] nbytes,
  output logic              ready,
  output logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data,
  output logic              tx_en,
  output logic [DATA_W-1:0] tx_data
);

  localparam int B     = 8 / DATA_W;
  localparam int CNT_W = (ADDR_W > 8) ? ADDR_W : 8;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PRE  = 3'd1;
  localparam logic [2:0] SFD  = 3'd2;
  localparam logic [2:0] BODY = 3'd3;
  localparam logic [2:0] PAD  = 3'd4;
  localparam logic [2:0] FCS  = 3'd5;
  localparam logic [2:0] IFG  = 3'd6;

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_BYTES - 1);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_BYTES - 1);
  localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(3);
  localparam logic [31:0]      POLY     = 32'hEDB88320;
  localparam logic [31:0]      CRC_INIT = 32'hFFFFFFFF;

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              beat;
  logic [ADDR_W-1:0] len;
  logic [31:0]       crc;

  logic              last_beat;
  logic [2:0]        post_body;
  logic [CNT_W-1:0]  post_cnt;
  logic [7:0]        cur_byte;
  logic [7:0]        fcs_byte;
  logic [7:0]        beat_byte;

  // Reflected CRC-32, one whole byte per call.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  assign last_beat = (B == 1) ? 1'b1 : beat;

`ifdef ETH_TX_PAD_EN
  localparam logic [CNT_W-1:0] MIN_BODY  = CNT_W'(60);
  localparam logic [CNT_W-1:0] PAD_LAST  = CNT_W'(59);
  logic short_frame;
  // Pad counter resumes from the body length so it ends at 60 total bytes.
  assign short_frame = CNT_W'(len) < MIN_BODY;
  assign post_body   = short_frame ? PAD : FCS;
  assign post_cnt    = short_frame ? CNT_W'(len) : '0;
`else
  assign post_body   = FCS;
  assign post_cnt    = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      beat  <= 1'b0;
      len   <= '0;
      addr  <= '0;
      crc   <= CRC_INIT;
    end else begin
      if (state != IDLE)
        beat <= (B == 2) ? ~beat : 1'b0;
      case (state)
        IDLE: if (send) begin
          len   <= nbytes;
          crc   <= CRC_INIT;
          addr  <= '0;
          cnt   <= '0;
          beat  <= 1'b0;
          state <= PRE;
        end
        PRE: if (last_beat) begin
          if (cnt == PRE_LAST) begin
            cnt   <= '0;
            state <= SFD;
          end else cnt <= cnt + 1'b1;
        end
        SFD: if (last_beat) begin
          if (len != '0) begin
            cnt   <= '0;
            state <= BODY;
          end else begin
            cnt   <= post_cnt;
            state <= post_body;
          end
        end
        BODY: if (last_beat) begin
          crc  <= crc_byte(crc, data);
          addr <= addr + 1'b1;
          if (addr == len - 1'b1) begin
            cnt   <= post_cnt;
            state <= post_body;
          end
        end
`ifdef ETH_TX_PAD_EN
        PAD: if (last_beat) begin
          crc <= crc_byte(crc, 8'h00);
          if (cnt == PAD_LAST) begin
            cnt   <= '0;
            state <= FCS;
          end else cnt <= cnt + 1'b1;
        end
`endif
        FCS: if (last_beat) begin
          if (cnt == FCS_LAST) begin
            cnt   <= '0;
            state <= IFG;
          end else cnt <= cnt + 1'b1;
        end
        IFG: if (last_beat) begin
          if (cnt == IFG_LAST) begin
            cnt   <= '0;
            addr  <= '0;
            state <= IDLE;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    fcs_byte = 8'h00;
    case (cnt[1:0])
      2'd0: fcs_byte = ~crc[7:0];
      2'd1: fcs_byte = ~crc[15:8];
      2'd2: fcs_byte = ~crc[23:16];
      default: fcs_byte = ~crc[31:24];
    endcase
  end

  always_comb begin
    cur_byte = 8'h00;
    case (state)
      PRE:     cur_byte = 8'h55;
      SFD:     cur_byte = 8'hD5;
      BODY:    cur_byte = data;
      FCS:     cur_byte = fcs_byte;
      default: cur_byte = 8'h00;
    endcase
  end

  // Outputs decode straight from state so reset clears them without a clock.
  assign ready     = (state == IDLE);
  assign tx_en     = (state == PRE) || (state == SFD) || (state == BODY) ||
                     (state == PAD) || (state == FCS);
  assign beat_byte = beat ? {4'h0, cur_byte[7:4]} : cur_byte;
  assign tx_data   = tx_en ? beat_byte[DATA_W-1:0] : '0;

endmodule

// File: tb/tb_iob_eth_tx_gen.sv
// Self-checking bench: GMII and MII instances side by side against a byte-level frame model.
module tb_iob_eth_tx_gen;
  localparam int ADDR_W = 11;
`ifdef ETH_TX_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, send8 = 1'b0, send4 = 1'b0;
  logic [ADDR_W-1:0] nbytes = '0, addr8, addr4;
  logic ready8, ready4, tx_en8, tx_en4;
  logic [7:0] data8, data4, tx_data8;
  logic [3:0] tx_data4;
  logic [7:0] mem [0:(1<<ADDR_W)-1];

  assign data8 = mem[addr8];
  assign data4 = mem[addr4];
  always #5 clk = ~clk;

  iob_eth_tx_gen #(.DATA_W(8), .ADDR_W(ADDR_W), .IFG_BYTES(12), .PREAMBLE_BYTES(7)) u8 (
    .clk(clk), .rst(rst), .send(send8), .nbytes(nbytes), .ready(ready8), .addr(addr8),
    .data(data8), .tx_en(tx_en8), .tx_data(tx_data8));
  iob_eth_tx_gen #(.DATA_W(4), .ADDR_W(ADDR_W), .IFG_BYTES(12), .PREAMBLE_BYTES(7)) u4 (
    .clk(clk), .rst(rst), .send(send4), .nbytes(nbytes), .ready(ready4), .addr(addr4),
    .data(data4), .tx_en(tx_en4), .tx_data(tx_data4));

  int total = 0, npass = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Frame capture, sampled on the falling edge.
  logic [7:0] cur8[$], last8[$], last4[$];
  logic [3:0] cur4[$];
  int nfr8 = 0, nfr4 = 0, cyc8 = 0, cyc4 = 0, lcyc8 = 0, lcyc4 = 0;
  int gap8 = 0, gap4 = 0, lgap8 = 0, lgap4 = 0;

  always @(negedge clk) begin
    if (rst) begin cur8.delete(); cyc8 = 0; end
    else if (tx_en8) begin
      if (cyc8 == 0) lgap8 = gap8;
      cur8.push_back(tx_data8); cyc8++;
    end else if (cyc8 != 0) begin
      last8 = cur8; lcyc8 = cyc8; nfr8++; cur8.delete(); cyc8 = 0; gap8 = 1;
    end else gap8++;
  end

  always @(negedge clk) begin
    if (rst) begin cur4.delete(); cyc4 = 0; end
    else if (tx_en4) begin
      if (cyc4 == 0) lgap4 = gap4;
      cur4.push_back(tx_data4); cyc4++;
    end else if (cyc4 != 0) begin
      last4.delete();
      for (int i = 0; i + 1 < cur4.size(); i += 2) last4.push_back({cur4[i+1], cur4[i]});
      lcyc4 = cyc4; nfr4++; cur4.delete(); cyc4 = 0; gap4 = 1;
    end else gap4++;
  end

  // Reference: the frame as a byte list built from the framing rules.
  logic [7:0] exp_q[$];
  task automatic build_exp(input int len);
    logic [31:0] c;
    logic [7:0] b;
    int L;
    L = (PAD && len < 60) ? 60 : len;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < L; i++) begin
      b = (i < len) ? mem[i] : 8'h00;
      exp_q.push_back(b);
      for (int k = 0; k < 8; k++)
        if (c[0] ^ b[k]) c = (c >> 1) ^ 32'hEDB88320; else c = c >> 1;
    end
    c = ~c;
    for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
  endtask

  task automatic cmp_frame(input string nm, input bit w8, input int len);
    int mis, n;
    build_exp(len);
    mis = 0;
    n = w8 ? last8.size() : last4.size();
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= n) mis++;
      else if (w8 ? (last8[i] !== exp_q[i]) : (last4[i] !== exp_q[i])) mis++;
    chk({nm, w8 ? "_bytes8" : "_bytes4"}, 64'(mis), 64'(0));
    chk({nm, w8 ? "_cyc8" : "_cyc4"}, 64'(w8 ? lcyc8 : lcyc4),
        64'(exp_q.size() * (w8 ? 1 : 2)));
  endtask

  task automatic wait_done(input int e8, input int e4);
    int n;
    n = 0;
    while ((nfr8 < e8 || nfr4 < e4 || !ready8 || !ready4) && n < 5000) begin
      @(negedge clk); n++;
    end
    chk("frame_timeout", 64'(n < 5000), 64'(1));
  endtask

  task automatic run_frame(input int len);
    int b8, b4;
    b8 = nfr8; b4 = nfr4;
    nbytes = ADDR_W'(len); send8 = 1'b1; send4 = 1'b1;
    @(posedge clk); #1;
    send8 = 1'b0; send4 = 1'b0;
    chk("start8", 64'({ready8, tx_en8, tx_data8}), 64'({1'b0, 1'b1, 8'h55}));
    chk("start4", 64'({ready4, tx_en4, tx_data4}), 64'({1'b0, 1'b1, 4'h5}));
    wait_done(b8 + 1, b4 + 1);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
  endtask

  task automatic fill_ascii();
    for (int i = 0; i < 9; i++) mem[i] = 8'(8'h31 + i);
  endtask

  task automatic b2b(input bit w8);
    int base, n, mis;
    logic [7:0] f1[$];
    fill_rand();
    nbytes = ADDR_W'(64);
    base = w8 ? nfr8 : nfr4;
    if (w8) send8 = 1'b1; else send4 = 1'b1;
    n = 0;
    while ((w8 ? nfr8 : nfr4) < base + 1 && n < 3000) begin @(negedge clk); n++; end
    if (w8) f1 = last8; else f1 = last4;
    while (!(w8 ? tx_en8 : tx_en4) && n < 3000) begin @(negedge clk); n++; end
    send8 = 1'b0; send4 = 1'b0;
    chk("b2b_timeout", 64'(n < 3000), 64'(1));
    wait_done(w8 ? base + 2 : nfr8, w8 ? nfr4 : base + 2);
    chk(w8 ? "b2b_gap8" : "b2b_gap4", 64'(w8 ? lgap8 : lgap4), 64'(w8 ? 13 : 25));
    mis = 0;
    for (int i = 0; i < f1.size(); i++)
      if (w8 ? (last8[i] !== f1[i]) : (last4[i] !== f1[i])) mis++;
    chk(w8 ? "b2b_same8" : "b2b_same4", 64'(mis), 64'(0));
    cmp_frame("b2b", w8, 64);
  endtask

  typedef struct { int len; int cyc_np; int cyc_p; } vec_t;
  vec_t tbl[7];

  initial begin
    int n, b8, b4;
    tbl[0] = '{0, 12, 72};   tbl[1] = '{1, 13, 72};   tbl[2] = '{9, 21, 72};
    tbl[3] = '{59, 71, 72};  tbl[4] = '{60, 72, 72};  tbl[5] = '{64, 76, 76};
    tbl[6] = '{100, 112, 112};
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;

    #2;
    chk("reset8", 64'({ready8, tx_en8, addr8, tx_data8}), 64'({1'b1, 1'b0, 11'd0, 8'd0}));
    chk("reset4", 64'({ready4, tx_en4, addr4, tx_data4}), 64'({1'b1, 1'b0, 11'd0, 4'd0}));
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // Known check frame "123456789".
    fill_ascii();
    run_frame(9);
    cmp_frame("ascii", 1'b1, 9);
    cmp_frame("ascii", 1'b0, 9);
`ifndef ETH_TX_PAD_EN
    chk("ascii_fcs8", 64'({last8[20], last8[19], last8[18], last8[17]}), 64'(32'hCBF43926));
    chk("ascii_fcs4", 64'({last4[20], last4[19], last4[18], last4[17]}), 64'(32'hCBF43926));
`endif

    foreach (tbl[k]) begin
      fill_rand();
      run_frame(tbl[k].len);
      chk("tbl_cyc8", 64'(lcyc8), 64'(PAD ? tbl[k].cyc_p : tbl[k].cyc_np));
      chk("tbl_cyc4", 64'(lcyc4), 64'(2 * (PAD ? tbl[k].cyc_p : tbl[k].cyc_np)));
      cmp_frame("tbl", 1'b1, tbl[k].len);
      cmp_frame("tbl", 1'b0, tbl[k].len);
    end

    for (int r = 0; r < 6; r++) begin
      int len;
      len = int'($urandom_range(0, 90));
      fill_rand();
      run_frame(len);
      cmp_frame("rand", 1'b1, len);
      cmp_frame("rand", 1'b0, len);
    end

    b2b(1'b1);
    b2b(1'b0);

    // send pulses and nbytes changes while busy must not disturb or queue.
    fill_rand();
    b8 = nfr8; b4 = nfr4;
    nbytes = ADDR_W'(30); send8 = 1'b1; send4 = 1'b1;
    @(posedge clk); #1;
    send8 = 1'b0; send4 = 1'b0;
    repeat (20) @(negedge clk);
    nbytes = ADDR_W'(5); send8 = 1'b1; send4 = 1'b1;
    repeat (3) @(negedge clk);
    send8 = 1'b0; send4 = 1'b0;
    wait_done(b8 + 1, b4 + 1);
    cmp_frame("busy", 1'b1, 30);
    cmp_frame("busy", 1'b0, 30);
    repeat (80) @(negedge clk);
    chk("busy_noqueue8", 64'(nfr8 - b8), 64'(1));
    chk("busy_noqueue4", 64'(nfr4 - b4), 64'(1));

    // Reset in the middle of body byte 20.
    fill_rand();
    nbytes = ADDR_W'(40); send8 = 1'b1;
    @(posedge clk); #1;
    send8 = 1'b0;
    n = 0;
    while (!(tx_en8 && addr8 == 11'd20) && n < 500) begin @(negedge clk); n++; end
    chk("rst_reach", 64'(n < 500), 64'(1));
    b8 = nfr8;
    rst = 1'b1; #1;
    chk("rst_mid", 64'({tx_en8, ready8, addr8, tx_data8}), 64'({1'b0, 1'b1, 11'd0, 8'd0}));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_nofcs", 64'(nfr8 - b8), 64'(0));
    fill_ascii();
    run_frame(9);
    cmp_frame("post_rst", 1'b1, 9);
    cmp_frame("post_rst", 1'b0, 9);

    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1);
  end
endmodule
